forwarding_scoreboard: RTL and testbench

FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

---
 rtl/forwarding_scoreboard.sv | 98 +++++++++
 tb/tb_forwarding_scoreboard.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// In-flight destination tracker for an in-order pipeline: picks forwarding sources
// for each source port of the issuing instruction and stalls when a result is not ready yet.
module forwarding_scoreboard #(
    parameter  int NPORTS = 2,
    parameter  int DEPTH  = 3,
    parameter  int AW     = 5,
    localparam int SW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [NPORTS*AW-1:0] id_rs,
    input  logic [NPORTS-1:0]    id_rs_used,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_regwrite,
    input  logic [SW-1:0]        id_ready_stage,
    output logic [NPORTS*SW-1:0] fwd_sel,
    output logic                 stall,
    output logic                 accept,
    output logic [31:0]          stall_count
);

    logic [DEPTH:1]  ent_valid;
    logic [AW-1:0]   ent_rd  [1:DEPTH];
    logic [SW-1:0]   ent_rdy [1:DEPTH];
    logic [31:0]     stall_cnt;

    logic [NPORTS-1:0] hazard;
    logic [AW-1:0]     rs_cur;
    logic              found;
    logic [SW-1:0]     rdy_in;
    logic              insert;

    // Out-of-range ready stages are clamped into 1..DEPTH before being stored.
    always_comb begin
        rdy_in = id_ready_stage;
        if (id_ready_stage == '0)
            rdy_in = SW'(1);
        else if (int'(id_ready_stage) > DEPTH)
            rdy_in = SW'(DEPTH);
    end

    // Only the youngest matching entry (lowest stage) decides forward vs. hazard.
    always_comb begin
        fwd_sel = '0;
        hazard  = '0;
        rs_cur  = '0;
        found   = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            rs_cur = id_rs[p*AW +: AW];
            found  = 1'b0;
            if (id_valid && id_rs_used[p] && !rst && rs_cur != '0) begin
                for (int k = 1; k <= DEPTH; k++) begin
                    if (!found && ent_valid[k] && ent_rd[k] == rs_cur) begin
                        found = 1'b1;
                        if (SW'(k) >= ent_rdy[k])
                            fwd_sel[p*SW +: SW] = SW'(k);
                        else
                            hazard[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall       = |hazard;
    assign accept      = id_valid & ~stall & ~flush & ~hold & ~rst;
    assign insert      = accept & id_regwrite & (id_rd != '0);
    assign stall_count = stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                ent_rd[k]  <= '0;
                ent_rdy[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (!hold) begin
                for (int k = DEPTH; k >= 2; k--) begin
                    ent_valid[k] <= ent_valid[k-1];
                    ent_rd[k]    <= ent_rd[k-1];
                    ent_rdy[k]   <= ent_rdy[k-1];
                end
                ent_valid[1] <= insert;
                ent_rd[1]    <= id_rd;
                ent_rdy[1]   <= rdy_in;
            end
            // A squashed or frozen stall is not a lost issue slot, so it is not counted.
            if (stall && !hold && !flush && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: directed scenarios plus randomized traffic
// checked against an age-based model of in-flight results.
module tb_forwarding_scoreboard;

    localparam int NPORTS = 2;
    localparam int DEPTH  = 3;
    localparam int AW     = 5;
    localparam int SW     = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 hold = 1'b0;
    logic                 flush = 1'b0;
    logic                 id_valid = 1'b0;
    logic [NPORTS*AW-1:0] id_rs = '0;
    logic [NPORTS-1:0]    id_rs_used = '0;
    logic [AW-1:0]        id_rd = '0;
    logic                 id_regwrite = 1'b0;
    logic [SW-1:0]        id_ready_stage = '0;
    logic [NPORTS*SW-1:0] fwd_sel;
    logic                 stall;
    logic                 accept;
    logic [31:0]          stall_count;

    int n_checks = 0;
    int n_errors = 0;

    forwarding_scoreboard #(.NPORTS(NPORTS), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_ready_stage(id_ready_stage), .fwd_sel(fwd_sel), .stall(stall),
        .accept(accept), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Model: each issued result is remembered with its age in unfrozen cycles; age == stage.
    typedef struct { int rd; int rdy; int age; } ent_t;
    ent_t mq[$];
    logic [NPORTS*SW-1:0] exp_fwd;
    logic                 exp_stall;
    logic                 exp_accept;
    logic [31:0]          exp_cnt = '0;

    function automatic int clamp_rdy(int r);
        if (r == 0) return 1;
        if (r > DEPTH) return DEPTH;
        return r;
    endfunction

    function automatic void model_eval();
        exp_fwd   = '0;
        exp_stall = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (id_valid && id_rs_used[p]) begin
                int rs;
                int best;
                rs   = int'(id_rs[p*AW +: AW]);
                best = -1;
                foreach (mq[i])
                    if (rs != 0 && mq[i].rd == rs && (best < 0 || mq[i].age < mq[best].age))
                        best = i;
                if (best >= 0) begin
                    if (mq[best].age >= mq[best].rdy) exp_fwd[p*SW +: SW] = SW'(mq[best].age);
                    else exp_stall = 1'b1;
                end
            end
        end
        exp_accept = id_valid && !exp_stall && !flush && !hold;
    endfunction

    function automatic void model_step();
        ent_t e;
        if (exp_stall && !hold && !flush && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        if (!hold) begin
            foreach (mq[i]) mq[i].age++;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].age > DEPTH) mq.delete(i);
            if (exp_accept && id_regwrite && id_rd != 0) begin
                e.rd = int'(id_rd); e.rdy = clamp_rdy(int'(id_ready_stage)); e.age = 1;
                mq.push_back(e);
            end
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        hold = 0; flush = 0; id_valid = 0; id_rs = '0; id_rs_used = '0;
        id_rd = '0; id_regwrite = 0; id_ready_stage = '0;
    endtask

    task automatic issue(int rd, int rdy, int rs0, int rs1, logic [1:0] used);
        id_valid = 1; id_rd = AW'(rd); id_regwrite = 1; id_ready_stage = SW'(rdy);
        id_rs = {AW'(rs1), AW'(rs0)}; id_rs_used = used;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        mq.delete();
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        issue(5, 1, 5, 5, 2'b11);
        #1;
        n_checks++;
        if (fwd_sel !== '0 || stall !== 1'b0 || accept !== 1'b0 || stall_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: fwd=%0h stall=%0b accept=%0b cnt=%0h, want all 0",
                     fwd_sel, stall, accept, stall_count);
        end
        do_reset();
    endtask

    task automatic test_forward_alu();
        do_reset();
        issue(5, 1, 0, 0, 2'b00);
        tick();
        issue(8, 1, 5, 0, 2'b01);
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0 || accept !== 1'b1) begin
            n_errors++;
            $display("FAIL alu_forward: fwd0=%0d stall=%0b accept=%0b, want 1 0 1",
                     fwd_sel[1:0], stall, accept);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(7, 2, 0, 0, 2'b00);
        tick();
        issue(9, 1, 0, 7, 2'b10);
        #1;
        n_checks++;
        if (stall !== 1'b1 || accept !== 1'b0) begin
            n_errors++;
            $display("FAIL load_use_stall: stall=%0b accept=%0b, want 1 0", stall, accept);
        end
        tick();
        #1;
        n_checks++;
        if (stall_count !== 32'd1 || fwd_sel[3:2] !== 2'd2 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL load_use_fwd: cnt=%0d fwd1=%0d stall=%0b, want 1 2 0",
                     stall_count, fwd_sel[3:2], stall);
        end
        tick();
    endtask

    task automatic test_youngest();
        do_reset();
        issue(3, 1, 0, 0, 2'b00);
        tick();
        issue(3, 1, 0, 0, 2'b00);
        tick();
        issue(0, 1, 3, 0, 2'b01);
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL youngest_wins: fwd0=%0d stall=%0b, want 1 0", fwd_sel[1:0], stall);
        end
        tick();
        issue(4, 1, 0, 0, 2'b01);
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL x0_no_match: fwd0=%0d stall=%0b, want 0 0", fwd_sel[1:0], stall);
        end
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        issue(9, 1, 0, 0, 2'b00);
        tick();
        idle();
        hold = 1;
        tick();
        tick();
        issue(10, 1, 9, 0, 2'b01);
        hold = 1;
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd1 || accept !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_freeze: fwd0=%0d accept=%0b, want 1 0", fwd_sel[1:0], accept);
        end
        idle();
        tick();
        id_valid = 1; id_rs = {AW'(0), AW'(9)}; id_rs_used = 2'b01;
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd2) begin
            n_errors++;
            $display("FAIL hold_shift1: fwd0=%0d, want 2", fwd_sel[1:0]);
        end
        idle();
        tick();
        tick();
        id_valid = 1; id_rs = {AW'(0), AW'(9)}; id_rs_used = 2'b01;
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_expire: fwd0=%0d stall=%0b, want 0 0", fwd_sel[1:0], stall);
        end
        idle();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        issue(4, 1, 0, 0, 2'b00);
        flush = 1;
        #1;
        n_checks++;
        if (accept !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_accept: accept=%0b, want 0", accept);
        end
        tick();
        idle();
        issue(1, 1, 4, 0, 2'b01);
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_no_insert: fwd0=%0d stall=%0b, want 0 0", fwd_sel[1:0], stall);
        end
        tick();
        issue(7, 3, 0, 0, 2'b00);
        tick();
        issue(2, 1, 7, 0, 2'b01);
        flush = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_stall_visible: stall=%0b, want 1", stall);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_errors++;
            $display("FAIL flush_stall_uncounted: cnt=%0d, want 0", stall_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(6, 1, 6, 0, 2'b01);
        #1;
        n_checks++;
        if (fwd_sel[1:0] !== 2'd0 || stall !== 1'b0 || accept !== 1'b1) begin
            n_errors++;
            $display("FAIL self_dep_first: fwd0=%0d stall=%0b accept=%0b, want 0 0 1",
                     fwd_sel[1:0], stall, accept);
        end
        tick();
        issue(6, 0, 6, 6, 2'b11);
        #1;
        n_checks++;
        if (fwd_sel !== 4'b0101 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL self_dep_older: fwd=%0h stall=%0b, want 5 0", fwd_sel, stall);
        end
        tick();
        // ready_stage 0 was clamped to 1, so the consumer forwards from stage 1 at once.
        issue(12, 1, 0, 6, 2'b10);
        #1;
        n_checks++;
        if (fwd_sel[3:2] !== 2'd1 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_zero_clamp: fwd1=%0d stall=%0b, want 1 0", fwd_sel[3:2], stall);
        end
        tick();
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_errors;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            hold        = ($urandom_range(0, 9) < 2);
            flush       = ($urandom_range(0, 9) < 1);
            id_valid    = ($urandom_range(0, 9) < 7);
            id_rs       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            id_rs_used  = NPORTS'($urandom_range(0, 3));
            id_rd       = AW'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_ready_stage = SW'($urandom_range(0, 3));
            #1;
            model_eval();
            n_checks++;
            if (fwd_sel !== exp_fwd || stall !== exp_stall || accept !== exp_accept) begin
                n_errors++;
                if (n_errors - errs_before < 10)
                    $display("FAIL random_comb c=%0d: fwd=%0h stall=%0b acc=%0b, want %0h %0b %0b",
                             c, fwd_sel, stall, accept, exp_fwd, exp_stall, exp_accept);
            end
            tick();
            n_checks++;
            if (stall_count !== exp_cnt) begin
                n_errors++;
                if (n_errors - errs_before < 10)
                    $display("FAIL random_count c=%0d: cnt=%0d, want %0d", c, stall_count, exp_cnt);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(20, 3, 0, 0, 2'b00);
        tick();
        issue(1, 1, 20, 0, 2'b01);
        tick();
        tick();
        issue(10, 1, 0, 0, 2'b00);
        tick();
        issue(11, 1, 0, 0, 2'b00);
        tick();
        issue(12, 1, 0, 0, 2'b00);
        tick();
        issue(13, 1, 10, 12, 2'b11);
        #1;
        n_checks++;
        if (fwd_sel !== 4'b0111 || stall_count !== 32'd2 || accept !== 1'b1) begin
            n_errors++;
            $display("FAIL prefill: fwd=%0h cnt=%0d accept=%0b, want 7 2 1",
                     fwd_sel, stall_count, accept);
        end
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (fwd_sel !== '0 || stall !== 1'b0 || accept !== 1'b0 || stall_count !== 32'd0) begin
            n_errors++;
            $display("FAIL async_reset: fwd=%0h stall=%0b accept=%0b cnt=%0d, want all 0",
                     fwd_sel, stall, accept, stall_count);
        end
        mq.delete();
        exp_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        n_checks++;
        if (fwd_sel !== '0 || stall !== 1'b0 || accept !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_issue: fwd=%0h stall=%0b accept=%0b, want 0 0 1",
                     fwd_sel, stall, accept);
        end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        issue(7, 3, 0, 0, 2'b00);
        tick();
        issue(2, 1, 7, 0, 2'b01);
        tick();
        #1;
        n_checks++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL sat_reach: cnt=%0h, want ffffffff", stall_count);
        end
        tick();
        #1;
        n_checks++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL sat_hold: cnt=%0h, want ffffffff", stall_count);
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_forward_alu();
        test_load_use();
        test_youngest();
        test_hold();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
